// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: handshaked RV32I execute stage with registered writeback and branch redirect.
// Define ALU_EXEC_MULDIV_EN to build the RV32M multiplier and the iterative restoring divider.
module alu_exec_pipe #(
    parameter int unsigned W_PD_DATA  = 32,
    parameter int unsigned W_AA_INSTR = 32,
    parameter int unsigned W_PD_UOPS  = 6,
    parameter int unsigned W_PD_TAG   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  DFI_valid,
    output logic                  DFO_ready,
    input  logic [W_PD_UOPS-1:0]  DFI_PD_uops,
    input  logic [W_PD_DATA-1:0]  DFI_PD_rs,
    input  logic [W_PD_DATA-1:0]  DFI_PD_rt,
    input  logic [W_PD_DATA-1:0]  DFI_PD_imm,
    input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
    input  logic [W_PD_TAG-1:0]   DFI_PD_tag,
    input  logic                  DFI_flush,
    input  logic                  DFI_ready,
    output logic                  DFO_valid,
    output logic [W_PD_DATA-1:0]  DFO_PD_RD1,
    output logic [W_AA_INSTR-1:0] DFO_AA_BR,
    output logic                  DFO_br_taken,
    output logic [W_PD_TAG-1:0]   DFO_PD_tag,
    output logic                  DFO_illegal
);

    localparam int unsigned SHW = $clog2(W_PD_DATA);
    localparam int unsigned CW  = $clog2(W_PD_DATA + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD
`ifdef ALU_EXEC_MULDIV_EN
        , S_DIV
`endif
    } state_t;

    state_t state;

    logic [5:0]            uop;
    logic                  is_imm;
    logic                  br_op;
    logic [W_PD_DATA-1:0]  opa;
    logic [W_PD_DATA-1:0]  opb;
    logic [W_PD_DATA-1:0]  jalr_sum;
    logic [SHW-1:0]        shamt;
    logic [W_AA_INSTR-1:0] pc_seq;
    logic [W_AA_INSTR-1:0] pc_tgt;
    logic [W_PD_DATA-1:0]  c_rd1;
    logic [W_AA_INSTR-1:0] c_br;
    logic                  c_taken;
    logic                  c_ill;
    logic                  take;

`ifdef ALU_EXEC_MULDIV_EN
    logic                    c_div;
    logic [2*W_PD_DATA-1:0]  mul_a;
    logic [2*W_PD_DATA-1:0]  mul_b;
    logic [2*W_PD_DATA-1:0]  mul_prod;
    logic                    div_sa;
    logic                    div_sb;
    logic [W_PD_DATA-1:0]    div_rem;
    logic [W_PD_DATA-1:0]    div_quo;
    logic [W_PD_DATA-1:0]    div_dvs;
    logic [W_PD_DATA-1:0]    div_dvd;
    logic [CW-1:0]           div_cnt;
    logic                    div_neg_q;
    logic                    div_neg_r;
    logic                    div_zero;
    logic                    div_is_rem;
    logic [W_PD_TAG-1:0]     div_tag;
    logic [W_AA_INSTR-1:0]   div_pc_seq;
    logic [W_PD_DATA:0]      div_sh;
    logic                    div_ge;
    logic [W_PD_DATA-1:0]    div_q;
    logic [W_PD_DATA-1:0]    div_r;
    logic [W_PD_DATA-1:0]    div_res;
`endif

    assign DFO_ready = !DFI_flush && ((state == S_IDLE) || ((state == S_HOLD) && DFI_ready));
    assign take      = DFI_valid && DFO_ready;

    // Single-cycle result of the offered micro-op
    always_comb begin
        uop      = 6'(DFI_PD_uops);
        is_imm   = (uop[5:3] == 3'b010) || (uop == 6'b011010);
        opa      = DFI_PD_rs;
        opb      = is_imm ? DFI_PD_imm : DFI_PD_rt;
        shamt    = opb[SHW-1:0];
        pc_seq   = DFI_AA_pc + W_AA_INSTR'(4);
        pc_tgt   = DFI_AA_pc + W_AA_INSTR'(DFI_PD_imm);
        jalr_sum = opa + DFI_PD_imm;
        c_rd1    = '0;
        c_br     = pc_seq;
        c_taken  = 1'b0;
        c_ill    = 1'b0;
        br_op    = 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
        c_div    = 1'b0;
`endif
        case (uop)
            6'b000000, 6'b010000: c_rd1 = opa + opb;
            6'b000001, 6'b010001: c_rd1 = opa << shamt;
            6'b000010, 6'b010010: c_rd1 = W_PD_DATA'($signed(opa) < $signed(opb));
            6'b000011, 6'b010011: c_rd1 = W_PD_DATA'(opa < opb);
            6'b000100, 6'b010100: c_rd1 = opa ^ opb;
            6'b000101, 6'b010101: c_rd1 = opa >> shamt;
            6'b000110, 6'b010110: c_rd1 = opa | opb;
            6'b000111, 6'b010111: c_rd1 = opa & opb;
            6'b001100:            c_rd1 = opa - opb;
            6'b001101, 6'b011010: c_rd1 = $signed(opa) >>> shamt;
            6'b011000: begin br_op = 1'b1; c_taken = (opa == opb); end
            6'b011001: begin br_op = 1'b1; c_taken = (opa != opb); end
            6'b011100: begin br_op = 1'b1; c_taken = ($signed(opa) < $signed(opb)); end
            6'b011101: begin br_op = 1'b1; c_taken = ($signed(opa) >= $signed(opb)); end
            6'b011110: begin br_op = 1'b1; c_taken = (opa < opb); end
            6'b011111: begin br_op = 1'b1; c_taken = (opa >= opb); end
            6'b100000: c_rd1 = W_PD_DATA'(DFI_AA_pc) + DFI_PD_imm;
            6'b100001: begin
                c_rd1   = W_PD_DATA'(pc_seq);
                c_br    = pc_tgt;
                c_taken = 1'b1;
            end
            6'b100010: begin
                c_rd1   = W_PD_DATA'(pc_seq);
                c_br    = W_AA_INSTR'(jalr_sum) & ~W_AA_INSTR'(1);
                c_taken = 1'b1;
            end
`ifdef ALU_EXEC_MULDIV_EN
            6'b101000:                       c_rd1 = mul_prod[W_PD_DATA-1:0];
            6'b101001, 6'b101010, 6'b101011: c_rd1 = mul_prod[2*W_PD_DATA-1:W_PD_DATA];
            6'b101100, 6'b101101,
            6'b101110, 6'b101111:            c_div = 1'b1;
`endif
            default: c_ill = 1'b1;
        endcase
        if (br_op && c_taken) begin
            c_br = pc_tgt;
        end
    end

`ifdef ALU_EXEC_MULDIV_EN
    // Multiplier operands sign-extended per MULH/MULHSU/MULHU; divider magnitudes and step
    always_comb begin
        mul_a    = ((uop[1:0] == 2'b01) || (uop[1:0] == 2'b10)) ?
                   {{W_PD_DATA{opa[W_PD_DATA-1]}}, opa} : {{W_PD_DATA{1'b0}}, opa};
        mul_b    = (uop[1:0] == 2'b01) ?
                   {{W_PD_DATA{DFI_PD_rt[W_PD_DATA-1]}}, DFI_PD_rt} : {{W_PD_DATA{1'b0}}, DFI_PD_rt};
        mul_prod = mul_a * mul_b;
        div_sa   = !uop[0] && DFI_PD_rs[W_PD_DATA-1];
        div_sb   = !uop[0] && DFI_PD_rt[W_PD_DATA-1];
        div_sh   = {div_rem, div_quo[W_PD_DATA-1]};
        div_ge   = div_sh >= {1'b0, div_dvs};
        div_q    = div_neg_q ? -div_quo : div_quo;
        div_r    = div_neg_r ? -div_rem : div_rem;
        if (div_zero) begin
            div_q = '1;
            div_r = div_dvd;
        end
        div_res  = div_is_rem ? div_r : div_q;
    end
`endif

    // Handshake FSM with registered result; flush overrides accept and downstream ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            DFO_valid    <= 1'b0;
            DFO_PD_RD1   <= '0;
            DFO_AA_BR    <= '0;
            DFO_br_taken <= 1'b0;
            DFO_PD_tag   <= '0;
            DFO_illegal  <= 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
            div_rem      <= '0;
            div_quo      <= '0;
            div_dvs      <= '0;
            div_dvd      <= '0;
            div_cnt      <= '0;
            div_neg_q    <= 1'b0;
            div_neg_r    <= 1'b0;
            div_zero     <= 1'b0;
            div_is_rem   <= 1'b0;
            div_tag      <= '0;
            div_pc_seq   <= '0;
`endif
        end else if (DFI_flush) begin
            state     <= S_IDLE;
            DFO_valid <= 1'b0;
        end else if (take) begin
`ifdef ALU_EXEC_MULDIV_EN
            if (c_div) begin
                state      <= S_DIV;
                DFO_valid  <= 1'b0;
                div_rem    <= '0;
                div_quo    <= div_sa ? -DFI_PD_rs : DFI_PD_rs;
                div_dvs    <= div_sb ? -DFI_PD_rt : DFI_PD_rt;
                div_dvd    <= DFI_PD_rs;
                div_cnt    <= '0;
                div_neg_q  <= div_sa ^ div_sb;
                div_neg_r  <= div_sa;
                div_zero   <= (DFI_PD_rt == '0);
                div_is_rem <= uop[1];
                div_tag    <= DFI_PD_tag;
                div_pc_seq <= pc_seq;
            end else
`endif
            begin
                state        <= S_HOLD;
                DFO_valid    <= 1'b1;
                DFO_PD_RD1   <= c_rd1;
                DFO_AA_BR    <= c_br;
                DFO_br_taken <= c_taken;
                DFO_PD_tag   <= DFI_PD_tag;
                DFO_illegal  <= c_ill;
            end
        end else begin
            case (state)
                S_HOLD: begin
                    if (DFI_ready) begin
                        state     <= S_IDLE;
                        DFO_valid <= 1'b0;
                    end
                end
`ifdef ALU_EXEC_MULDIV_EN
                S_DIV: begin
                    if (div_cnt == CW'(W_PD_DATA)) begin
                        state        <= S_HOLD;
                        DFO_valid    <= 1'b1;
                        DFO_PD_RD1   <= div_res;
                        DFO_AA_BR    <= div_pc_seq;
                        DFO_br_taken <= 1'b0;
                        DFO_PD_tag   <= div_tag;
                        DFO_illegal  <= 1'b0;
                    end else begin
                        div_rem <= div_ge ? W_PD_DATA'(div_sh - {1'b0, div_dvs}) : div_sh[W_PD_DATA-1:0];
                        div_quo <= {div_quo[W_PD_DATA-2:0], div_ge};
                        div_cnt <= div_cnt + CW'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_pipe.md
# alu_exec_pipe

Parametrised, handshaked execute stage for the RV32I integer pipe: it registers one micro-op per accepted transfer and produces a registered writeback result plus a resolved branch/jump redirect. Its successor features are XLEN generalisation, a destination-tag passthrough, flush, backpressure, and an optional multi-cycle RV32M multiply/divide unit. It sits between the issue/operand-read stage and writeback/fetch-redirect.

## Interface
- W_PD_DATA, 32: operand/result width (XLEN), ≥ 8, power of two.
- W_AA_INSTR, 32: PC/target width, ≤ W_PD_DATA.
- W_PD_UOPS, 6: micro-op width.
- W_PD_TAG, 4: destination tag width.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- DFI_valid  input  1  upstream holds a valid micro-op.
- DFO_ready  output  1  stage can accept this cycle.
- DFI_PD_uops  input  W_PD_UOPS  micro-op code.
- DFI_PD_rs, DFI_PD_rt  input  W_PD_DATA  source operands.
- DFI_PD_imm  input  W_PD_DATA  immediate, already fully sign-extended by decode (AUIPC: already shifted left by 12).
- DFI_AA_pc  input  W_AA_INSTR  instruction PC.
- DFI_PD_tag  input  W_PD_TAG  destination tag.
- DFI_flush  input  1  synchronous kill of in-flight and held work.
- DFI_ready  input  1  downstream accepts the result.
- DFO_valid  output  1  result valid.
- DFO_PD_RD1  output  W_PD_DATA  writeback value.
- DFO_AA_BR  output  W_AA_INSTR  redirect target.
- DFO_br_taken  output  1  redirect required (taken branch, JAL, or JALR).
- DFO_PD_tag  output  W_PD_TAG  tag of the result.
- DFO_illegal  output  1  unrecognised micro-op; RD1 = 0 and br_taken = 0.

## Operation
- Uops (binary): ADD 000000, SLL 000001, SLT 000010, SLTU 000011, XOR 000100, SRL 000101, OR 000110, AND 000111, SUB 001100, SRA 001101; ADDI..ANDI 010000–010111, SRAI 011010; BEQ 011000, BNE 011001, BLT 011100, BGE 011101, BLTU 011110, BGEU 011111; AUIPC 100000, JAL 100001, JALR 100010; MUL 101000, MULH 101001, MULHSU 101010, MULHU 101011, DIV 101100, DIVU 101101, REM 101110, REMU 101111.
- Shift amount: low log2(W_PD_DATA) bits of rt/imm. SLT/SLTU/SLTI/SLTIU produce 1 or 0.
- Branch target = pc + imm. Not taken: DFO_AA_BR = pc + 4 and br_taken = 0. JAL: pc + imm. JALR: (rs + imm) with bit 0 cleared. JAL/JALR write pc + 4; AUIPC writes pc + imm with br_taken = 0. Branches write RD1 = 0.
- FSM states: IDLE, DIV, HOLD.
  - IDLE: accept when DFI_valid && DFO_ready. A single-cycle op goes to HOLD. A DIV-class op loads the divider and goes to DIV.
  - DIV: restoring divider, one quotient bit per cycle for W_PD_DATA cycles, then result to output register, then HOLD.
  - HOLD: DFO_valid = 1. On DFI_ready, return to IDLE, or accept the next op directly if one is offered.
- DFO_ready = !DFI_flush && (state == IDLE || (state == HOLD && DFI_ready)).
- Divide by zero: quotient all-ones, remainder = dividend.
- Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
- Divider sign handling: magnitudes are computed, then results are negated.
- DFI_flush: next state IDLE, DFO_valid drops, divider aborted. Flush wins over a simultaneous accept and over a simultaneous DFI_ready.
- Outputs are held stable while DFO_valid && !DFI_ready.
- Reset: state IDLE; DFO_valid, DFO_PD_RD1, DFO_AA_BR, DFO_br_taken, DFO_PD_tag, DFO_illegal all 0. Reset mid-divide discards the operation.

## Timing
- Single-cycle ops: accepted at edge N; DFO_valid visible after edge N.
- Back-to-back throughput is 1 op per cycle when DFI_ready stays high.
- DIV-class: accepted at edge N; DFO_valid after edge N + W_PD_DATA + 1 (33 for W_PD_DATA = 32). Latency is fixed, including the zero and overflow cases.
- MUL-class: single-cycle, same latency as ALU ops.
- DFO_ready is combinational from state, DFI_ready, and DFI_flush. No other input-to-output combinational paths exist.

## Configuration
- ALU_EXEC_MULDIV_EN defined: MUL/DIV/REM micro-ops are implemented as described, and the DIV state exists.
- ALU_EXEC_MULDIV_EN undefined: multiplier, divider and DIV state are not compiled. The 101xxx uops complete in one cycle with DFO_illegal = 1, RD1 = 0, br_taken = 0.

## Test plan
- Reset, then ADD rs=5, rt=7, tag=3 with DFI_ready=1 → one cycle later DFO_valid=1, RD1=12, tag=3, br_taken=0. Also check every output is 0 during reset.
- BLT rs=0xFFFFFFFF, rt=1, pc=0x100, imm=0x20 → br_taken=1, BR=0x120. BLTU with the same operands → br_taken=0, BR=0x104.
- JALR rs=0x1001, imm=2, pc=0x40 → BR=0x1002, RD1=0x44, br_taken=1.
- DIV 0x80000000 / 0xFFFFFFFF → RD1=0x80000000 after 33 cycles. DIVU 7/0 → 0xFFFFFFFF. REM −7/2 → 0xFFFFFFFF. With the macro off, DIV → DFO_illegal=1 after 1 cycle.
- Backpressure: DFI_ready=0 for 5 cycles with a second op offered → DFO_ready=0 and the first result is held unchanged. Raise DFI_ready → the second op is accepted the same cycle.
- Flush at cycle 10 of a DIV, offered simultaneously with a new op → DFO_valid stays 0, the new op is not accepted, and the next op is accepted the following cycle.
